// File: rtl/cpu_ctrl.sv
// cpu_ctrl: multicycle FETCH/DECODE/EXEC/MEM/WB sequencer for the 16-bit-instruction CPU; owns pc (= R0).
// Define CPU_CTRL_STEP_EN to add a 'step' input that lets FETCH advance once per rising edge of step.
module cpu_ctrl #(
    parameter int DW = 8,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          run,
`ifdef CPU_CTRL_STEP_EN
    input  logic          step,
`endif
    output logic [AW-1:0] inst_addr,
    input  logic [15:0]   inst,
    output logic [3:0]    rf_ra1,
    output logic [3:0]    rf_ra2,
    input  logic [DW-1:0] rf_rd1,
    input  logic [DW-1:0] rf_rd2,
    output logic          rf_we,
    output logic [3:0]    rf_wa,
    output logic [DW-1:0] rf_wd,
    output logic [3:0]    alu_op,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    input  logic [DW-1:0] alu_y,
    output logic          mem_req,
    output logic          mem_we,
    output logic [DW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          busy,
    output logic          halted
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_e;

    localparam logic [3:0]  OP_NOP    = 4'd0;
    localparam logic [3:0]  OP_LOAD   = 4'd1;
    localparam logic [3:0]  OP_STORE  = 4'd2;
    localparam logic [3:0]  OP_SET    = 4'd3;
    localparam logic [3:0]  OP_LT     = 4'd4;
    localparam logic [3:0]  OP_EQ     = 4'd5;
    localparam logic [3:0]  OP_BEQ    = 4'd6;
    localparam logic [3:0]  OP_BNEQ   = 4'd7;
    localparam logic [15:0] HALT_INST = 16'hFFFF;

    state_e        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [15:0]   ir_q, ir_d;
    logic [DW-1:0] opa_q, opa_d;
    logic [DW-1:0] opb_q, opb_d;
    logic [DW-1:0] wval_q, wval_d;
    logic [DW-1:0] maddr_q, maddr_d;

    logic [3:0]    op, fld_a, fld_b, fld_c;
    logic [7:0]    imm8;
    logic          is_alu;
    logic          reads_a_field;
    logic          br_equal;
    logic          br_taken;
    logic          fetch_go;
    logic [DW-1:0] rd1_val, rd2_val;
    logic [AW-1:0] pc_inc1, pc_inc2;

    assign op    = ir_q[15:12];
    assign fld_a = ir_q[11:8];
    assign fld_b = ir_q[7:4];
    assign fld_c = ir_q[3:0];
    assign imm8  = ir_q[7:0];

    assign is_alu        = (op == OP_LT) || (op == OP_EQ) || op[3];
    assign reads_a_field = (op == OP_STORE) || (op == OP_BEQ) || (op == OP_BNEQ);

    // R0 is the program counter; the external register file never stores it.
    assign rf_ra1  = fld_b;
    assign rf_ra2  = reads_a_field ? fld_a : fld_c;
    assign rd1_val = (rf_ra1 == 4'd0) ? DW'(pc_q) : rf_rd1;
    assign rd2_val = (rf_ra2 == 4'd0) ? DW'(pc_q) : rf_rd2;

    assign br_equal = ({8'd0, opb_q} == {{DW{1'b0}}, imm8});
    assign br_taken = (op == OP_BEQ) ? br_equal : !br_equal;

    assign pc_inc1 = pc_q + AW'(1);
    assign pc_inc2 = pc_q + AW'(2);

    assign inst_addr = pc_q;
    assign busy      = (state_q != S_FETCH) && (state_q != S_HALT);
    assign halted    = (state_q == S_HALT);

`ifdef CPU_CTRL_STEP_EN
    logic step_q, step_d;

    always_comb begin
        step_d = step;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            step_q <= 1'b0;
        end else begin
            step_q <= step_d;
        end
    end

    assign fetch_go = run && step && !step_q;
`else
    assign fetch_go = run;
`endif

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        wval_d    = wval_q;
        maddr_d   = maddr_q;
        rf_we     = 1'b0;
        rf_wa     = 4'd0;
        rf_wd     = '0;
        alu_op    = 4'd0;
        alu_a     = '0;
        alu_b     = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;

        case (state_q)
            S_FETCH: begin
                if (fetch_go) begin
                    ir_d    = inst;
                    state_d = S_DECODE;
                end
            end

            S_DECODE: begin
                opa_d   = rd1_val;
                opb_d   = rd2_val;
                state_d = S_EXEC;
            end

            S_EXEC: begin
                if (ir_q == HALT_INST) begin
                    state_d = S_HALT;
                end else if (is_alu) begin
                    alu_op  = op;
                    alu_a   = opa_q;
                    alu_b   = opb_q;
                    wval_d  = alu_y;
                    state_d = S_WB;
                end else begin
                    case (op)
                        OP_SET: begin
                            wval_d  = DW'(imm8);
                            state_d = S_WB;
                        end
                        OP_BEQ, OP_BNEQ: begin
                            pc_d    = br_taken ? pc_inc2 : pc_inc1;
                            state_d = S_FETCH;
                        end
                        OP_LOAD, OP_STORE: begin
                            maddr_d = opa_q + DW'(fld_c);
                            state_d = S_MEM;
                        end
                        default: begin
                            pc_d    = pc_inc1;
                            state_d = S_FETCH;
                        end
                    endcase
                end
            end

            // Address, direction and store data come from flops, so they hold until the ack.
            S_MEM: begin
                mem_req   = 1'b1;
                mem_we    = (op == OP_STORE);
                mem_addr  = maddr_q;
                mem_wdata = (op == OP_STORE) ? opb_q : '0;
                if (mem_ack) begin
                    if (op == OP_STORE) begin
                        pc_d    = pc_inc1;
                        state_d = S_FETCH;
                    end else begin
                        wval_d  = mem_rdata;
                        state_d = S_WB;
                    end
                end
            end

            S_WB: begin
                if (fld_a != 4'd0) begin
                    rf_we = 1'b1;
                    rf_wa = fld_a;
                    rf_wd = wval_q;
                    pc_d  = pc_inc1;
                end else begin
                    pc_d  = AW'(wval_q);
                end
                state_d = S_FETCH;
            end

            S_HALT: begin
                state_d = S_HALT;
            end

            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
        if (!rst_n) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            wval_q  <= '0;
            maddr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            wval_q  <= wval_d;
            maddr_q <= maddr_d;
        end
    end

endmodule

// File: tb/tb_cpu_ctrl.sv
// tb_cpu_ctrl: drives cpu_ctrl with a ROM, register file, ALU and memory responder, and compares
// it with an instruction-level model of the CPU.
module tb_cpu_ctrl;

    localparam int DW = 8;
    localparam int AW = 8;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          run   = 1'b0;
`ifdef CPU_CTRL_STEP_EN
    logic          step  = 1'b0;
`endif
    logic [AW-1:0] inst_addr;
    logic [15:0]   inst;
    logic [3:0]    rf_ra1, rf_ra2, rf_wa, alu_op;
    logic [DW-1:0] rf_rd1, rf_rd2, rf_wd, alu_a, alu_b, alu_y;
    logic          rf_we, mem_req, mem_we, busy, halted;
    logic [DW-1:0] mem_addr, mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ack   = 1'b0;

    logic [15:0]   rom [256];
    logic [DW-1:0] rf  [16] = '{default: 8'h00};
    int            we_count = 0;

    int            pass_cnt  = 0;
    int            total_cnt = 0;

    logic          resp_en    = 1'b1;
    int            ack_delay  = 0;
    logic [7:0]    salt       = 8'h5A;
    logic          force_tgl  = 1'b0;
    logic          force_seen = 1'b0;
    int            wait_cnt   = 0;
    int            st_count   = 0;
    logic [7:0]    st_addr    = '0;
    logic [7:0]    st_data    = '0;

    int            obs_cycles, obs_mem_cycles, obs_last_mem, obs_we_at;
    logic          obs_mem_stable, obs_mwe;
    logic [7:0]    obs_maddr, obs_mwdata, obs_we_wd;
    logic [3:0]    obs_we_wa;

    cpu_ctrl #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .run(run),
`ifdef CPU_CTRL_STEP_EN
        .step(step),
`endif
        .inst_addr(inst_addr), .inst(inst),
        .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .busy(busy), .halted(halted)
    );

    always #5 clk = ~clk;

    // Environment ALU: 4 LT, 5 EQ, 8 ADD, 9 SUB, 10 AND, 11 OR, 12 SHL, 13 SHR, 14 INV, 15 XOR.
    function automatic logic [7:0] alu_model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            4'd4:    return (a < b) ? 8'd1 : 8'd0;
            4'd5:    return (a == b) ? 8'd1 : 8'd0;
            4'd8:    return a + b;
            4'd9:    return a - b;
            4'd10:   return a & b;
            4'd11:   return a | b;
            4'd12:   return (b >= 8'd8) ? 8'd0 : (a << b);
            4'd13:   return (b >= 8'd8) ? 8'd0 : (a >> b);
            4'd14:   return ~a;
            4'd15:   return a ^ b;
            default: return 8'd0;
        endcase
    endfunction

    assign inst   = rom[inst_addr];
    assign rf_rd1 = rf[rf_ra1];
    assign rf_rd2 = rf[rf_ra2];
    assign alu_y  = alu_model(alu_op, alu_a, alu_b);

    always @(posedge clk) begin
        if (rf_we) begin
            rf[rf_wa] <= rf_wd;
            we_count  <= we_count + 1;
        end
    end

    // Memory responder: acks ack_delay cycles after mem_req is seen; load data = addr ^ salt.
    always @(negedge clk) begin
        if (mem_ack) begin
            mem_ack = 1'b0;
        end else if (force_tgl != force_seen) begin
            force_seen = force_tgl;
            mem_ack    = 1'b1;
            mem_rdata  = 8'hEE;
        end else if (mem_req && resp_en) begin
            if (wait_cnt >= ack_delay) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_addr ^ salt;
                wait_cnt  = 0;
                if (mem_we) begin
                    st_count = st_count + 1;
                    st_addr  = mem_addr;
                    st_data  = mem_wdata;
                end
            end else begin
                wait_cnt = wait_cnt + 1;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic rom_clear();
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        run   = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Runs one instruction from FETCH to the next FETCH (or HALT), recording what the DUT drove.
    task automatic run_instr(input int delay);
        ack_delay      = delay;
        obs_cycles     = 0;
        obs_mem_cycles = 0;
        obs_last_mem   = 0;
        obs_we_at      = 0;
        obs_mem_stable = 1'b1;
        obs_mwe        = 1'b0;
        obs_maddr      = '0;
        obs_mwdata     = '0;
        obs_we_wa      = '0;
        obs_we_wd      = '0;
`ifdef CPU_CTRL_STEP_EN
        step = 1'b1;
`endif
        do begin
            @(negedge clk);
`ifdef CPU_CTRL_STEP_EN
            step = 1'b0;
`endif
            obs_cycles++;
            if (mem_req) begin
                if (obs_mem_cycles == 0) begin
                    obs_maddr  = mem_addr;
                    obs_mwe    = mem_we;
                    obs_mwdata = mem_wdata;
                end else if (mem_addr !== obs_maddr || mem_we !== obs_mwe || mem_wdata !== obs_mwdata) begin
                    obs_mem_stable = 1'b0;
                end
                obs_mem_cycles++;
                obs_last_mem = obs_cycles;
            end
            if (rf_we) begin
                obs_we_at = obs_cycles;
                obs_we_wa = rf_wa;
                obs_we_wd = rf_wd;
            end
        end while (busy !== 1'b0 && obs_cycles < 60);
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL instr_completes: busy=%b after %0d cycles, required 0", busy, obs_cycles);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        logic [68:0] outs;
        do_reset();
        outs = {inst_addr, rf_ra1, rf_ra2, rf_we, rf_wa, rf_wd, alu_op, alu_a, alu_b,
                mem_req, mem_we, mem_addr, mem_wdata, busy, halted};
        total_cnt++;
        if (outs !== '0) $display("FAIL reset_outputs: got %h, required 0", outs);
        else pass_cnt++;
        repeat (3) @(negedge clk);
        total_cnt++;
        if (inst_addr !== 8'd0 || busy !== 1'b0) $display("FAIL reset_hold: inst_addr=%h busy=%b, required 00/0", inst_addr, busy);
        else pass_cnt++;
    endtask

    task automatic test_store_prog();
        int bad_lat;
        int st_before;
        rom_clear();
        rom[0] = 16'h3220; // SET R2,0x20
        rom[1] = 16'h3180; // SET R1,0x80
        rom[2] = 16'h3320; // SET R3,0x20
        rom[3] = 16'h8423; // ADD R4,R2,R3
        rom[4] = 16'h2410; // STORE R4,R1,0
        do_reset();
        run = 1'b1;
        bad_lat = 0;
        for (int i = 0; i < 4; i++) begin
            run_instr(0);
            if (obs_cycles != 4) bad_lat++;
        end
        total_cnt++;
        if (bad_lat != 0) $display("FAIL set_add_latency: %0d instructions not 4 cycles, required 0", bad_lat);
        else pass_cnt++;
        total_cnt++;
        if (rf[4] !== 8'h40 || inst_addr !== 8'd4) $display("FAIL add_result: R4=%h pc=%h, required 40/04", rf[4], inst_addr);
        else pass_cnt++;
        st_before = st_count;
        run_instr(2);
        total_cnt++;
        if (obs_mem_cycles != 3 || obs_maddr !== 8'h80 || obs_mwdata !== 8'h40 || obs_mwe !== 1'b1 || !obs_mem_stable)
            $display("FAIL store_bus: cyc=%0d addr=%h wdata=%h we=%b stable=%b, required 3/80/40/1/1",
                     obs_mem_cycles, obs_maddr, obs_mwdata, obs_mwe, obs_mem_stable);
        else pass_cnt++;
        total_cnt++;
        if (obs_cycles != 6 || inst_addr !== 8'd5 || st_count != st_before + 1)
            $display("FAIL store_retire: cycles=%0d pc=%h stores=%0d, required 6/05/%0d", obs_cycles, inst_addr, st_count, st_before + 1);
        else pass_cnt++;
    endtask

    task automatic test_branch();
        logic [3:0] ops  [4] = '{4'd6, 4'd6, 4'd7, 4'd7};
        logic [7:0] vals [4] = '{8'h20, 8'h21, 8'h20, 8'h21};
        logic [7:0] exps [4] = '{8'd12, 8'd11, 8'd11, 8'd12};
        int we_before;
        for (int t = 0; t < 4; t++) begin
            rom_clear();
            rom[0]  = {8'h32, vals[t]};     // SET R2,val
            rom[1]  = 16'h300A;             // SET R0,10 (jump)
            rom[10] = {ops[t], 12'h220};    // BEQ/BNEQ R2,0x20
            do_reset();
            run = 1'b1;
            run_instr(0);
            run_instr(0);
            we_before = we_count;
            run_instr(0);
            total_cnt++;
            if (obs_cycles != 3 || inst_addr !== exps[t] || we_count != we_before)
                $display("FAIL branch_%0d: cycles=%0d next=%h writes=%0d, required 3/%h/0",
                         t, obs_cycles, inst_addr, we_count - we_before, exps[t]);
            else pass_cnt++;
        end
    endtask

    task automatic test_jump_wrap();
        int we_before;
        rom_clear();
        rom[0]   = 16'h30FF; // SET R0,0xFF
        rom[255] = 16'h0000; // NOP
        do_reset();
        run = 1'b1;
        we_before = we_count;
        run_instr(0);
        total_cnt++;
        if (inst_addr !== 8'hFF || we_count != we_before || obs_we_at != 0)
            $display("FAIL jump_abs: pc=%h writes=%0d, required FF/0", inst_addr, we_count - we_before);
        else pass_cnt++;
        run_instr(0);
        total_cnt++;
        if (inst_addr !== 8'h00) $display("FAIL wrap_plus1: pc=%h, required 00", inst_addr);
        else pass_cnt++;

        rom_clear();
        rom[0]   = 16'h3220; // SET R2,0x20
        rom[1]   = 16'h30FF; // SET R0,0xFF
        rom[255] = 16'h6220; // BEQ R2,0x20 (taken)
        do_reset();
        run = 1'b1;
        repeat (3) run_instr(0);
        total_cnt++;
        if (inst_addr !== 8'h01) $display("FAIL wrap_plus2: pc=%h, required 01", inst_addr);
        else pass_cnt++;
    endtask

    task automatic test_load_delay();
        rom_clear();
        rom[0] = 16'h3110; // SET R1,0x10
        rom[1] = 16'h1513; // LOAD R5,R1,3
        do_reset();
        run = 1'b1;
        run_instr(0);
        run_instr(3);
        total_cnt++;
        if (obs_cycles != 8 || obs_mem_cycles != 4)
            $display("FAIL load_latency: total=%0d mem=%0d, required 8/4", obs_cycles, obs_mem_cycles);
        else pass_cnt++;
        total_cnt++;
        if (obs_maddr !== 8'h13 || obs_mwe !== 1'b0 || !obs_mem_stable)
            $display("FAIL load_bus: addr=%h we=%b stable=%b, required 13/0/1", obs_maddr, obs_mwe, obs_mem_stable);
        else pass_cnt++;
        total_cnt++;
        if (obs_we_at != obs_last_mem + 1 || obs_we_wa !== 4'd5 || obs_we_wd !== (8'h13 ^ salt) || rf[5] !== (8'h13 ^ salt))
            $display("FAIL load_wb: at=%0d wa=%h wd=%h, required %0d/5/%h",
                     obs_we_at, obs_we_wa, obs_we_wd, obs_last_mem + 1, 8'h13 ^ salt);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_mem();
        int waited;
        logic [18:0] outs;
        rom_clear();
        rom[0] = 16'h3140; // SET R1,0x40
        rom[1] = 16'h2110; // STORE R1,R1,0
        resp_en = 1'b0;
        do_reset();
        run = 1'b1;
        run_instr(0);
`ifdef CPU_CTRL_STEP_EN
        step = 1'b1;
`endif
        waited = 0;
        do begin
            @(negedge clk);
`ifdef CPU_CTRL_STEP_EN
            step = 1'b0;
`endif
            waited++;
        end while (mem_req !== 1'b1 && waited < 20);
        repeat (2) @(negedge clk);
        total_cnt++;
        if (mem_req !== 1'b1 || mem_addr !== 8'h40) $display("FAIL mem_wait: req=%b addr=%h, required 1/40", mem_req, mem_addr);
        else pass_cnt++;
        rst_n = 1'b0;
        @(negedge clk);
        outs = {mem_req, mem_we, rf_we, busy, halted, inst_addr, mem_addr};
        total_cnt++;
        if (outs !== '0) $display("FAIL reset_in_mem: got %h, required 0", outs);
        else pass_cnt++;
        rst_n     = 1'b1;
        run       = 1'b0;
        force_tgl = ~force_tgl;
        repeat (3) @(negedge clk);
        total_cnt++;
        if (busy !== 1'b0 || inst_addr !== 8'd0) $display("FAIL late_ack: busy=%b pc=%h, required 0/00", busy, inst_addr);
        else pass_cnt++;
        resp_en = 1'b1;
        run     = 1'b1;
        run_instr(0);
        total_cnt++;
        if (obs_cycles != 4 || inst_addr !== 8'd1 || rf[1] !== 8'h40)
            $display("FAIL restart: cycles=%0d pc=%h R1=%h, required 4/01/40", obs_cycles, inst_addr, rf[1]);
        else pass_cnt++;
    endtask

    task automatic test_run_hold();
        int bad;
        rom_clear();
        rom[0] = 16'h3611; // SET R6,0x11
        do_reset();
        run = 1'b1;
        run_instr(0);
        run = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (inst_addr !== 8'd1 || busy !== 1'b0) bad++;
        end
        total_cnt++;
        if (bad != 0) $display("FAIL run_hold: %0d cycles moved or busy, required 0", bad);
        else pass_cnt++;
        run = 1'b1;
        run_instr(0);
        total_cnt++;
        if (obs_cycles != 3 || inst_addr !== 8'd2) $display("FAIL run_resume: cycles=%0d pc=%h, required 3/02", obs_cycles, inst_addr);
        else pass_cnt++;
    endtask

    task automatic test_halt();
        int we_before;
        rom_clear();
        rom[0] = 16'hFFFE; // XOR R15,R15,R14: ordinary instruction
        rom[1] = 16'hFFFF; // HALT encoding
        do_reset();
        run = 1'b1;
        run_instr(0);
        total_cnt++;
        if (halted !== 1'b0 || inst_addr !== 8'd1) $display("FAIL no_halt: halted=%b pc=%h, required 0/01", halted, inst_addr);
        else pass_cnt++;
        we_before = we_count;
        run_instr(0);
        repeat (5) @(negedge clk);
        total_cnt++;
        if (obs_cycles != 3 || halted !== 1'b1 || busy !== 1'b0 || inst_addr !== 8'd1 || we_count != we_before)
            $display("FAIL halt: cycles=%0d halted=%b busy=%b pc=%h writes=%0d, required 3/1/0/01/0",
                     obs_cycles, halted, busy, inst_addr, we_count - we_before);
        else pass_cnt++;
        do_reset();
        total_cnt++;
        if (halted !== 1'b0) $display("FAIL halt_reset: halted=%b, required 0", halted);
        else pass_cnt++;
    endtask

`ifdef CPU_CTRL_STEP_EN
    task automatic test_step();
        rom_clear();
        rom[0] = 16'h3701;
        rom[1] = 16'h3802;
        rom[2] = 16'h3903;
        rom[3] = 16'h3A04;
        do_reset();
        run = 1'b1;
        repeat (5) @(negedge clk);
        total_cnt++;
        if (inst_addr !== 8'd0 || busy !== 1'b0) $display("FAIL step_idle: pc=%h busy=%b, required 00/0", inst_addr, busy);
        else pass_cnt++;
        for (int p = 0; p < 3; p++) begin
            step = 1'b1;
            repeat (3) @(negedge clk);
            step = 1'b0;
            repeat (8) @(negedge clk);
        end
        total_cnt++;
        if (inst_addr !== 8'd3 || rf[9] !== 8'h03) $display("FAIL step_count: pc=%h R9=%h, required 03/03", inst_addr, rf[9]);
        else pass_cnt++;
        do_reset();
    endtask
`endif

    task automatic test_random();
        logic [7:0]  m_reg [16];
        logic [7:0]  m_pc, npc, va, vb, vc, val, ea, sv;
        logic [15:0] cur;
        logic [3:0]  op, fa, fb, fc;
        logic        do_wb, is_st, taken;
        int          lat, delay, st_before;
        for (int i = 0; i < 256; i++) begin
            rom[i] = 16'($urandom);
            if (rom[i] == 16'hFFFF) rom[i] = 16'hFFFE;
        end
        salt = 8'($urandom);
        do_reset();
        for (int r = 0; r < 16; r++) m_reg[r] = rf[r];
        m_pc = 8'd0;
        run  = 1'b1;
        for (int n = 0; n < 150; n++) begin
            cur = rom[m_pc];
            op  = cur[15:12];
            fa  = cur[11:8];
            fb  = cur[7:4];
            fc  = cur[3:0];
            va  = (fa == 4'd0) ? m_pc : m_reg[fa];
            vb  = (fb == 4'd0) ? m_pc : m_reg[fb];
            vc  = (fc == 4'd0) ? m_pc : m_reg[fc];
            delay = $urandom_range(0, 3);
            do_wb = 1'b0;
            is_st = 1'b0;
            val   = '0;
            ea    = '0;
            sv    = '0;
            npc   = m_pc + 8'd1;
            if (op == 4'd0) begin
                lat = 3;
            end else if (op == 4'd3) begin
                val = cur[7:0]; do_wb = 1'b1; lat = 4;
            end else if (op == 4'd6 || op == 4'd7) begin
                taken = (va == cur[7:0]) ^ (op == 4'd7);
                npc   = m_pc + (taken ? 8'd2 : 8'd1);
                lat   = 3;
            end else if (op == 4'd1) begin
                ea = vb + 8'(fc); val = ea ^ salt; do_wb = 1'b1; lat = 5 + delay;
            end else if (op == 4'd2) begin
                ea = vb + 8'(fc); sv = va; is_st = 1'b1; lat = 4 + delay;
            end else begin
                val = alu_model(op, vb, vc); do_wb = 1'b1; lat = 4;
            end
            if (do_wb) begin
                if (fa != 4'd0) m_reg[fa] = val;
                else npc = val;
            end
            st_before = st_count;
            run_instr(delay);
            total_cnt++;
            if (obs_cycles != lat || inst_addr !== npc || halted !== 1'b0)
                $display("FAIL rand_%0d inst=%h: cycles=%0d next=%h halted=%b, required %0d/%h/0",
                         n, cur, obs_cycles, inst_addr, halted, lat, npc);
            else pass_cnt++;
            if (is_st) begin
                total_cnt++;
                if (st_count != st_before + 1 || st_addr !== ea || st_data !== sv)
                    $display("FAIL rand_store_%0d: addr=%h data=%h, required %h/%h", n, st_addr, st_data, ea, sv);
                else pass_cnt++;
            end
            m_pc = npc;
        end
        for (int r = 1; r < 16; r++) begin
            total_cnt++;
            if (rf[r] !== m_reg[r]) $display("FAIL rand_reg_R%0d: got %h, required %h", r, rf[r], m_reg[r]);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_store_prog();
        test_branch();
        test_jump_wrap();
        test_load_delay();
        test_reset_mid_mem();
        test_run_hold();
        test_halt();
`ifdef CPU_CTRL_STEP_EN
        test_step();
`endif
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
